// File: rtl/frogger_pkg.sv
// Shared definitions for the Frogger game logic: phase encodings, grid geometry,
// score/level limits and the level-to-car-period mapping.
package frogger_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PLAYING   = 3'd1,
    ST_DYING     = 3'd2,
    ST_LEVEL_UP  = 3'd3,
    ST_GAME_OVER = 3'd4
  } state_e;

  localparam int unsigned COLS         = 20;
  localparam int unsigned ROWS         = 15;
  localparam int unsigned FROG_START_X = 1;
  localparam int unsigned FROG_START_Y = 14;

  localparam int unsigned SCORE_MAX = 99;
  localparam int unsigned MAX_LEVEL = 9;

  localparam int unsigned CAR_CNT_W = 8;

  // Traffic speeds up by two frames per level, never faster than one step every two frames.
  function automatic logic [CAR_CNT_W-1:0] car_period(input logic [3:0]  level,
                                                      input int unsigned base_frames);
    int p;
    p = int'(base_frames) - 2 * (int'(level) - 1);
    if (p < 2) p = 2;
    return CAR_CNT_W'(p);
  endfunction

endpackage

// File: rtl/frogger_speed_div.sv
// Frame-tick divider whose period follows the current level; emits a one-cycle
// registered tick each time a full period of frame ticks has elapsed.
module frogger_speed_div #(
  parameter int unsigned BASE_FRAMES = 16
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_Frame_Tick,
  input  logic       i_En,
  input  logic       i_Clr,
  input  logic [3:0] i_Level,
  output logic       o_Car_Tick
);
  import frogger_pkg::*;

  logic [CAR_CNT_W-1:0] period;
  logic [CAR_CNT_W-1:0] cnt_q, cnt_d;
  logic                 tick_q, tick_d;

  always_comb begin
    period = car_period(i_Level, BASE_FRAMES);
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (i_Clr) begin
      cnt_d = '0;
    end else if (i_En && i_Frame_Tick) begin
      // >= guards against a count left above a freshly shortened period
      if (cnt_q >= period - CAR_CNT_W'(1)) begin
        cnt_d  = '0;
        tick_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CAR_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign o_Car_Tick = tick_q;

endmodule

// File: rtl/frogger_game_ctrl.sv
// Frogger game sequencer: phase FSM, lives/score/level registers, frog respawn
// requests and level-paced lane traffic tick.
module frogger_game_ctrl #(
  parameter int unsigned LIVES           = 3,
  parameter int unsigned HOMES_PER_LEVEL = 5,
  parameter int unsigned MAX_LEVEL       = frogger_pkg::MAX_LEVEL,
  parameter int unsigned SCORE_MAX       = frogger_pkg::SCORE_MAX,
  parameter int unsigned DEATH_FRAMES    = 60,
  parameter int unsigned LEVEL_FRAMES    = 90,
  parameter int unsigned BASE_CAR_FRAMES = 16
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_Frame_Tick,
  input  logic       i_Start,
  input  logic       i_Frog_Home,
  input  logic       i_Collision,
  output logic       o_Game_Active,
  output logic       o_Frog_Respawn,
  output logic       o_Car_Tick,
  output logic [6:0] o_Score,
  output logic [1:0] o_Lives,
  output logic [3:0] o_Level,
  output logic [2:0] o_State,
  output logic       o_Game_Over
);
  import frogger_pkg::*;

  localparam int unsigned FRAME_MAX = (DEATH_FRAMES > LEVEL_FRAMES) ? DEATH_FRAMES : LEVEL_FRAMES;
  localparam int unsigned FRAME_W   = $clog2(FRAME_MAX + 1);
  localparam int unsigned HOME_W    = $clog2(HOMES_PER_LEVEL + 1);

  localparam logic [FRAME_W-1:0] DEATH_LAST = FRAME_W'(DEATH_FRAMES - 1);
  localparam logic [FRAME_W-1:0] LEVEL_LAST = FRAME_W'(LEVEL_FRAMES - 1);
  localparam logic [HOME_W-1:0]  HOME_LAST  = HOME_W'(HOMES_PER_LEVEL - 1);
  localparam logic [6:0]         SCORE_LIM  = 7'(SCORE_MAX);
  localparam logic [3:0]         LEVEL_LIM  = 4'(MAX_LEVEL);
  localparam logic [1:0]         LIVES_INIT = 2'(LIVES);

  state_e               state_q, state_d;
  logic                 start_prev_q;
  logic                 start_edge;
  logic [6:0]           score_q, score_d;
  logic [1:0]           lives_q, lives_d;
  logic [3:0]           level_q, level_d;
  logic [HOME_W-1:0]    home_q, home_d;
  logic [FRAME_W-1:0]   frame_q, frame_d;
  logic                 respawn_q, respawn_d;
  logic                 active_q, over_q;
  logic                 car_en, car_clr;

  always_comb begin
    state_d    = state_q;
    score_d    = score_q;
    lives_d    = lives_q;
    level_d    = level_q;
    home_d     = home_q;
    frame_d    = frame_q;
    respawn_d  = 1'b0;
    start_edge = i_Start & ~start_prev_q;

    case (state_q)
      ST_IDLE: begin
        if (start_edge) begin
          state_d   = ST_PLAYING;
          score_d   = '0;
          lives_d   = LIVES_INIT;
          level_d   = 4'd1;
          home_d    = '0;
          respawn_d = 1'b1;
        end
      end

      ST_PLAYING: begin
        if (i_Collision) begin
          state_d = ST_DYING;
          if (lives_q != '0) lives_d = lives_q - 2'd1;
        end else if (i_Frog_Home) begin
          if (score_q < SCORE_LIM) score_d = score_q + 7'd1;
          if (home_q == HOME_LAST) begin
            home_d  = '0;
            state_d = ST_LEVEL_UP;
            if (level_q < LEVEL_LIM) level_d = level_q + 4'd1;
          end else begin
            home_d    = home_q + HOME_W'(1);
            respawn_d = 1'b1;
          end
        end
      end

      ST_DYING: begin
        if (i_Frame_Tick) begin
          if (frame_q == DEATH_LAST) begin
            if (lives_q == '0) begin
              state_d = ST_GAME_OVER;
            end else begin
              state_d   = ST_PLAYING;
              respawn_d = 1'b1;
            end
          end else begin
            frame_d = frame_q + FRAME_W'(1);
          end
        end
      end

      ST_LEVEL_UP: begin
        if (i_Frame_Tick) begin
          if (frame_q == LEVEL_LAST) begin
            state_d   = ST_PLAYING;
            respawn_d = 1'b1;
          end else begin
            frame_d = frame_q + FRAME_W'(1);
          end
        end
      end

      ST_GAME_OVER: begin
        if (start_edge) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase

    // Every phase pause starts counting from zero.
    if (state_d != state_q) frame_d = '0;
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q      <= ST_IDLE;
      start_prev_q <= 1'b0;
      score_q      <= '0;
      lives_q      <= LIVES_INIT;
      level_q      <= 4'd1;
      home_q       <= '0;
      frame_q      <= '0;
      respawn_q    <= 1'b0;
      active_q     <= 1'b0;
      over_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_prev_q <= i_Start;
      score_q      <= score_d;
      lives_q      <= lives_d;
      level_q      <= level_d;
      home_q       <= home_d;
      frame_q      <= frame_d;
      respawn_q    <= respawn_d;
      active_q     <= (state_d == ST_PLAYING);
      over_q       <= (state_d == ST_GAME_OVER);
    end
  end

  assign car_en  = (state_q == ST_PLAYING);
  assign car_clr = (level_d != level_q);

  frogger_speed_div #(
    .BASE_FRAMES (BASE_CAR_FRAMES)
  ) u_speed_div (
    .i_Clk        (i_Clk),
    .i_Rst        (i_Rst),
    .i_Frame_Tick (i_Frame_Tick),
    .i_En         (car_en),
    .i_Clr        (car_clr),
    .i_Level      (level_q),
    .o_Car_Tick   (o_Car_Tick)
  );

  assign o_Game_Active  = active_q;
  assign o_Frog_Respawn = respawn_q;
  assign o_Score        = score_q;
  assign o_Lives        = lives_q;
  assign o_Level        = level_q;
  assign o_State        = state_q;
  assign o_Game_Over    = over_q;

endmodule

// File: tb/tb_frogger_game_ctrl.sv
// Bench for frogger_game_ctrl: a game-rules model checked every cycle, directed
// scenarios with literal expectations, then a randomized play phase.
module tb_frogger_game_ctrl;

  localparam int LIVES = 3, HOMES = 5, MAXL = 9, SMAX = 99;
  localparam int DF = 60, LF = 90, BASE = 16;

  logic       i_Clk = 1'b0;
  logic       i_Rst, i_Frame_Tick, i_Start, i_Frog_Home, i_Collision;
  logic       o_Game_Active, o_Frog_Respawn, o_Car_Tick, o_Game_Over;
  logic [6:0] o_Score;
  logic [1:0] o_Lives;
  logic [3:0] o_Level;
  logic [2:0] o_State;

  int vectors = 0, errors = 0;

  int m_state, m_score, m_lives, m_level, m_home, m_frame, m_car;
  bit m_resp, m_tick, m_prev, m_valid = 1'b0;

  always #5 i_Clk = ~i_Clk;

  frogger_game_ctrl #(
    .LIVES           (LIVES),
    .HOMES_PER_LEVEL (HOMES),
    .MAX_LEVEL       (MAXL),
    .SCORE_MAX       (SMAX),
    .DEATH_FRAMES    (DF),
    .LEVEL_FRAMES    (LF),
    .BASE_CAR_FRAMES (BASE)
  ) dut (
    .i_Clk          (i_Clk),
    .i_Rst          (i_Rst),
    .i_Frame_Tick   (i_Frame_Tick),
    .i_Start        (i_Start),
    .i_Frog_Home    (i_Frog_Home),
    .i_Collision    (i_Collision),
    .o_Game_Active  (o_Game_Active),
    .o_Frog_Respawn (o_Frog_Respawn),
    .o_Car_Tick     (o_Car_Tick),
    .o_Score        (o_Score),
    .o_Lives        (o_Lives),
    .o_Level        (o_Level),
    .o_State        (o_State),
    .o_Game_Over    (o_Game_Over)
  );

  task automatic cmp(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Game rules applied to the inputs that the next rising edge will sample.
  task automatic model_step();
    int  os, ol, p;
    bit  sedge;
    if (i_Rst) begin
      m_state = 0; m_score = 0; m_lives = LIVES; m_level = 1; m_home = 0;
      m_frame = 0; m_car = 0; m_resp = 0; m_tick = 0; m_prev = 0; m_valid = 1;
      return;
    end
    if (!m_valid) return;
    sedge = i_Start && !m_prev;
    os = m_state;
    ol = m_level;
    p = BASE - 2 * (m_level - 1);
    if (p < 2) p = 2;
    m_resp = 0;
    m_tick = 0;
    case (os)
      0: if (sedge) begin
           m_state = 1; m_score = 0; m_lives = LIVES; m_level = 1; m_home = 0; m_resp = 1;
         end
      1: if (i_Collision) begin
           m_state = 2;
           if (m_lives > 0) m_lives--;
         end else if (i_Frog_Home) begin
           if (m_score < SMAX) m_score++;
           m_home++;
           if (m_home == HOMES) begin
             m_home = 0; m_state = 3;
             if (m_level < MAXL) m_level++;
           end else m_resp = 1;
         end
      2: if (i_Frame_Tick) begin
           m_frame++;
           if (m_frame == DF) begin
             if (m_lives == 0) m_state = 4;
             else begin m_state = 1; m_resp = 1; end
           end
         end
      3: if (i_Frame_Tick) begin
           m_frame++;
           if (m_frame == LF) begin m_state = 1; m_resp = 1; end
         end
      4: if (sedge) m_state = 0;
      default: m_state = 0;
    endcase
    if (m_state != os) m_frame = 0;
    if (m_level != ol) m_car = 0;
    else if (os == 1 && i_Frame_Tick) begin
      m_car++;
      if (m_car == p) begin m_car = 0; m_tick = 1; end
    end
    m_prev = i_Start;
  endtask

  always @(negedge i_Clk) begin
    if (m_valid) begin
      cmp("state",     int'(o_State),        m_state);
      cmp("score",     int'(o_Score),        m_score);
      cmp("lives",     int'(o_Lives),        m_lives);
      cmp("level",     int'(o_Level),        m_level);
      cmp("respawn",   int'(o_Frog_Respawn), int'(m_resp));
      cmp("car_tick",  int'(o_Car_Tick),     int'(m_tick));
      cmp("active",    int'(o_Game_Active),  int'(m_state == 1));
      cmp("game_over", int'(o_Game_Over),    int'(m_state == 4));
    end
    model_step();
  end

  task automatic step(input logic ft, input logic st, input logic hm,
                      input logic col, input logic rst);
    i_Frame_Tick = ft;
    i_Start      = st;
    i_Frog_Home  = hm;
    i_Collision  = col;
    i_Rst        = rst;
    @(posedge i_Clk);
    #1;
  endtask

  task automatic wait_state(input int s, input int budget);
    int n = 0;
    while (int'(o_State) != s && n < budget) begin
      step(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0, 1'b0);
      n++;
    end
    cmp("wait_state", int'(o_State), s);
  endtask

  task automatic measure_period(input string name, input int exp);
    int n = 0;
    while (!o_Car_Tick && n < 200) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      n++;
    end
    cmp({name, "_seen"}, int'(o_Car_Tick), 1);
    n = 0;
    do begin
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      n++;
    end while (!o_Car_Tick && n < 200);
    cmp(name, n, exp);
  endtask

  // One death pause of DF frame ticks with random collision/home noise, which must be ignored.
  task automatic death_pause(input int exp_after);
    for (int i = 0; i < DF - 1; i++)
      step(1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
    cmp("dying_hold", int'(o_State), 2);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cmp("dying_exit", int'(o_State), exp_after);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, errors so far %0d", errors);
    $fatal(1);
  end

  initial begin
    i_Rst = 1'b1; i_Frame_Tick = 1'b0; i_Start = 1'b0; i_Frog_Home = 1'b0; i_Collision = 1'b0;
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cmp("rst_state", int'(o_State), 0);
    cmp("rst_lives", int'(o_Lives), 3);
    cmp("rst_score", int'(o_Score), 0);
    cmp("rst_level", int'(o_Level), 1);

    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cmp("start_state",   int'(o_State), 1);
    cmp("start_active",  int'(o_Game_Active), 1);
    cmp("start_respawn", int'(o_Frog_Respawn), 1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cmp("start_resp_end", int'(o_Frog_Respawn), 0);

    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      cmp("home_respawn", int'(o_Frog_Respawn), 1);
      step(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0, 1'b0);
    end
    cmp("home_score4", int'(o_Score), 4);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cmp("lvlup_state", int'(o_State), 3);
    cmp("lvlup_level", int'(o_Level), 2);
    cmp("lvlup_score", int'(o_Score), 5);
    for (int i = 0; i < LF - 1; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cmp("lvlup_hold", int'(o_State), 3);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cmp("lvlup_exit", int'(o_State), 1);
    cmp("lvlup_resp", int'(o_Frog_Respawn), 1);
    measure_period("period_lvl2", 14);

    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    cmp("simul_state", int'(o_State), 2);
    cmp("simul_score", int'(o_Score), 5);
    cmp("simul_lives", int'(o_Lives), 2);
    death_pause(1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cmp("death2_lives", int'(o_Lives), 1);
    death_pause(1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cmp("death3_lives", int'(o_Lives), 0);
    death_pause(4);
    cmp("over_flag",  int'(o_Game_Over), 1);
    cmp("over_score", int'(o_Score), 5);
    cmp("over_level", int'(o_Level), 2);

    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cmp("over_to_idle", int'(o_State), 0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cmp("replay_state", int'(o_State), 1);
    cmp("replay_score", int'(o_Score), 0);
    cmp("replay_lives", int'(o_Lives), 3);
    cmp("replay_level", int'(o_Level), 1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 99; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      if (o_State == 3'd3) wait_state(1, 2000);
    end
    cmp("sat_score", int'(o_Score), 99);
    cmp("sat_level", int'(o_Level), 9);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cmp("sat_lvlup_state", int'(o_State), 3);
    cmp("sat_lvlup_score", int'(o_Score), 99);
    cmp("sat_lvlup_level", int'(o_Level), 9);
    wait_state(1, 2000);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cmp("sat_score2", int'(o_Score), 99);
    measure_period("period_lvl9", 2);

    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cmp("mid_dying", int'(o_State), 2);
    for (int i = 0; i < 30; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    cmp("midrst_state",   int'(o_State), 0);
    cmp("midrst_lives",   int'(o_Lives), 3);
    cmp("midrst_score",   int'(o_Score), 0);
    cmp("midrst_respawn", int'(o_Frog_Respawn), 0);
    cmp("midrst_cartick", int'(o_Car_Tick), 0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    begin
      logic st = 1'b0;
      for (int i = 0; i < 4000; i++) begin
        if ($urandom_range(0, 19) == 0) st = ~st;
        step(1'($urandom_range(0, 1)), st,
             1'($urandom_range(0, 7) == 0),
             1'($urandom_range(0, 24) == 0),
             1'($urandom_range(0, 399) == 0));
      end
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
